// File: rtl/tpu_ctrl_if.sv
// Host/UB/VPU-facing signal bundle of the TPU command controller.
// The controller uses the slave modport; the host side uses master.
interface tpu_ctrl_if;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [5:0] cmd_w_addr_in;
    logic [5:0] cmd_w_loc_in;
    logic [5:0] cmd_x_addr_in;
    logic [5:0] cmd_x_loc_in;
    logic [5:0] cmd_b_addr_in;
    logic [5:0] cmd_b_loc_in;
    logic [5:0] cmd_out_addr_in;
    logic       cmd_w_transpose_in;
    logic       cmd_x_transpose_in;
    logic [3:0] cmd_pathway_in;
    logic [5:0] cmd_rows_in;
    logic       vpu_wb_valid_in;

    logic       ub_rd_weight_start_out;
    logic       ub_rd_input_start_out;
    logic       ub_rd_bias_start_out;
    logic       sys_switch_out;
    logic       ub_wr_addr_valid_out;
    logic [5:0] ub_rd_weight_addr_out;
    logic [5:0] ub_rd_weight_loc_out;
    logic [5:0] ub_rd_input_addr_out;
    logic [5:0] ub_rd_input_loc_out;
    logic [5:0] ub_rd_bias_addr_out;
    logic [5:0] ub_rd_bias_loc_out;
    logic [5:0] ub_wr_addr_out;
    logic       ub_rd_weight_transpose_out;
    logic       ub_rd_input_transpose_out;
    logic [3:0] vpu_data_pathway_out;
    logic       busy_out;
    logic       done_out;
    logic       err_out;

    modport master (
        output cmd_valid_in, cmd_w_addr_in, cmd_w_loc_in, cmd_x_addr_in, cmd_x_loc_in,
               cmd_b_addr_in, cmd_b_loc_in, cmd_out_addr_in, cmd_w_transpose_in,
               cmd_x_transpose_in, cmd_pathway_in, cmd_rows_in, vpu_wb_valid_in,
        input  cmd_ready_out, ub_rd_weight_start_out, ub_rd_input_start_out,
               ub_rd_bias_start_out, sys_switch_out, ub_wr_addr_valid_out,
               ub_rd_weight_addr_out, ub_rd_weight_loc_out, ub_rd_input_addr_out,
               ub_rd_input_loc_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out,
               ub_wr_addr_out, ub_rd_weight_transpose_out, ub_rd_input_transpose_out,
               vpu_data_pathway_out, busy_out, done_out, err_out
    );

    modport slave (
        input  cmd_valid_in, cmd_w_addr_in, cmd_w_loc_in, cmd_x_addr_in, cmd_x_loc_in,
               cmd_b_addr_in, cmd_b_loc_in, cmd_out_addr_in, cmd_w_transpose_in,
               cmd_x_transpose_in, cmd_pathway_in, cmd_rows_in, vpu_wb_valid_in,
        output cmd_ready_out, ub_rd_weight_start_out, ub_rd_input_start_out,
               ub_rd_bias_start_out, sys_switch_out, ub_wr_addr_valid_out,
               ub_rd_weight_addr_out, ub_rd_weight_loc_out, ub_rd_input_addr_out,
               ub_rd_input_loc_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out,
               ub_wr_addr_out, ub_rd_weight_transpose_out, ub_rd_input_transpose_out,
               vpu_data_pathway_out, busy_out, done_out, err_out
    );
endinterface

// File: rtl/tpu_ctrl.sv
// Single-command sequencer: load weights, switch array, stream inputs, then
// wait for the VPU writeback pulses (with timeout) before reporting done.
module tpu_ctrl #(
    parameter int unsigned W_SETTLE = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic      clk,
    input  logic      rst,
    tpu_ctrl_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(W_SETTLE - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_SWITCH, S_STREAM, S_WAIT_WB, S_DONE
    } state_e;

    typedef struct packed {
        logic [5:0] w_addr;
        logic [5:0] w_loc;
        logic [5:0] x_addr;
        logic [5:0] x_loc;
        logic [5:0] b_addr;
        logic [5:0] b_loc;
        logic [5:0] out_addr;
        logic       w_transpose;
        logic       x_transpose;
        logic [3:0] pathway;
    } cmd_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic err;
        logic w_start;
        logic x_start;
        logic b_start;
        logic sys_switch;
        logic wr_valid;
        cmd_t cmd;
    } out_t;

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d, cmd_in;
    logic [5:0] rows_q, rows_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] wb_cnt_q, wb_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    out_t       out_q, out_d;
    logic       accept;
    logic       timeout_hit;

    assign accept = bus.cmd_valid_in & out_q.ready;

    assign cmd_in = '{
        w_addr:      bus.cmd_w_addr_in,
        w_loc:       bus.cmd_w_loc_in,
        x_addr:      bus.cmd_x_addr_in,
        x_loc:       bus.cmd_x_loc_in,
        b_addr:      bus.cmd_b_addr_in,
        b_loc:       bus.cmd_b_loc_in,
        out_addr:    bus.cmd_out_addr_in,
        w_transpose: bus.cmd_w_transpose_in,
        x_transpose: bus.cmd_x_transpose_in,
        pathway:     bus.cmd_pathway_in
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            rows_q        <= '0;
            settle_q      <= '0;
            wb_cnt_q      <= '0;
            to_cnt_q      <= '0;
            out_q         <= '0;
            out_q.ready   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rows_q   <= rows_d;
            settle_q <= settle_d;
            wb_cnt_q <= wb_cnt_d;
            to_cnt_q <= to_cnt_d;
            out_q    <= out_d;
        end
    end

    // NOTE: every comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rows_d      = rows_q;
        settle_d    = settle_q;
        wb_cnt_d    = wb_cnt_q;
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_LOAD_W;
                    cmd_d    = cmd_in;
                    rows_d   = bus.cmd_rows_in;
                    settle_d = '0;
                    wb_cnt_d = '0;
                end
            end
            S_LOAD_W: begin
                if (settle_q == SETTLE_LAST) state_d = S_SWITCH;
                else                         settle_d = settle_q + 4'd1;
            end
            S_SWITCH: state_d = S_STREAM;
            S_STREAM: begin
                if (bus.vpu_wb_valid_in) wb_cnt_d = wb_cnt_q + 8'd1;
                to_cnt_d = '0;
                state_d  = (rows_q == 6'd0) ? S_DONE : S_WAIT_WB;
            end
            S_WAIT_WB: begin
                if (bus.vpu_wb_valid_in) wb_cnt_d = wb_cnt_q + 8'd1;
                to_cnt_d = to_cnt_q + 8'd1;
                // Completion is checked first so a last pulse beats a coincident timeout.
                if (wb_cnt_d >= {2'b00, rows_q}) begin
                    state_d = S_DONE;
                end else if (to_cnt_d == TIMEOUT_CNT) begin
                    state_d     = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: outputs are decoded from the next state and registered, so they
    // line up with state_q yet never carry combinational glitches off-chip.
    always_comb begin
        out_d            = '0;
        out_d.ready      = (state_d == S_IDLE);
        out_d.busy       = (state_d != S_IDLE);
        out_d.done       = (state_d == S_DONE);
        out_d.w_start    = (state_d == S_LOAD_W) && (state_q == S_IDLE);
        out_d.sys_switch = (state_d == S_SWITCH);
        out_d.x_start    = (state_d == S_STREAM);
        out_d.b_start    = (state_d == S_STREAM);
        out_d.wr_valid   = (state_d == S_STREAM);
        out_d.err        = out_q.err;
        if (accept)           out_d.err = 1'b0;
        else if (timeout_hit) out_d.err = 1'b1;
        if (state_d != S_IDLE) out_d.cmd = cmd_d;
    end

    assign bus.cmd_ready_out              = out_q.ready;
    assign bus.busy_out                   = out_q.busy;
    assign bus.done_out                   = out_q.done;
    assign bus.err_out                    = out_q.err;
    assign bus.ub_rd_weight_start_out     = out_q.w_start;
    assign bus.ub_rd_input_start_out      = out_q.x_start;
    assign bus.ub_rd_bias_start_out       = out_q.b_start;
    assign bus.sys_switch_out             = out_q.sys_switch;
    assign bus.ub_wr_addr_valid_out       = out_q.wr_valid;
    assign bus.ub_rd_weight_addr_out      = out_q.cmd.w_addr;
    assign bus.ub_rd_weight_loc_out       = out_q.cmd.w_loc;
    assign bus.ub_rd_input_addr_out       = out_q.cmd.x_addr;
    assign bus.ub_rd_input_loc_out        = out_q.cmd.x_loc;
    assign bus.ub_rd_bias_addr_out        = out_q.cmd.b_addr;
    assign bus.ub_rd_bias_loc_out         = out_q.cmd.b_loc;
    assign bus.ub_wr_addr_out             = out_q.cmd.out_addr;
    assign bus.ub_rd_weight_transpose_out = out_q.cmd.w_transpose;
    assign bus.ub_rd_input_transpose_out  = out_q.cmd.x_transpose;
    assign bus.vpu_data_pathway_out       = out_q.cmd.pathway;

endmodule

// File: tb/tb_tpu_ctrl.sv
// Scenario bench for tpu_ctrl: each task pushes the strobe events it expects,
// a negedge monitor pops and compares them as the controller emits them.
module tb_tpu_ctrl;

    localparam int W_SETTLE = 4;
    localparam int TIMEOUT  = 10;

    typedef enum int { EV_WSTART = 0, EV_SWITCH = 1, EV_STREAM = 2, EV_DONE = 3, EV_ERR = 4 } ev_e;
    typedef struct {
        ev_e         ev;
        int          cyc;
        logic [47:0] f;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   t0;
    int   n_pass;
    int   n_total;
    logic err_prev;
    exp_t exp_q[$];

    tpu_ctrl_if bus ();

    tpu_ctrl #(.W_SETTLE(W_SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] obs_fields();
        return {bus.ub_rd_weight_addr_out, bus.ub_rd_weight_loc_out, bus.ub_rd_input_addr_out,
                bus.ub_rd_input_loc_out, bus.ub_rd_bias_addr_out, bus.ub_rd_bias_loc_out,
                bus.ub_wr_addr_out, bus.ub_rd_weight_transpose_out, bus.ub_rd_input_transpose_out,
                bus.vpu_data_pathway_out};
    endfunction

    task automatic drive(input logic [47:0] f, input logic [5:0] rows);
        {bus.cmd_w_addr_in, bus.cmd_w_loc_in, bus.cmd_x_addr_in, bus.cmd_x_loc_in,
         bus.cmd_b_addr_in, bus.cmd_b_loc_in, bus.cmd_out_addr_in, bus.cmd_w_transpose_in,
         bus.cmd_x_transpose_in, bus.cmd_pathway_in} = f;
        bus.cmd_rows_in = rows;
    endtask

    task automatic push_ev(input ev_e ev, input int c, input logic [47:0] f);
        exp_t e;
        e.ev  = ev;
        e.cyc = c;
        e.f   = f;
        exp_q.push_back(e);
    endtask

    // Expected front half of every command: weight start, switch, stream.
    task automatic push_front(input int base, input logic [47:0] f);
        push_ev(EV_WSTART, base + 1, f);
        push_ev(EV_SWITCH, base + 1 + W_SETTLE, f);
        push_ev(EV_STREAM, base + 2 + W_SETTLE, f);
    endtask

    // Scoreboard side: every strobe the DUT produces must match the queue head.
    always @(negedge clk) begin : mon
        logic [4:0]  fired;
        logic [47:0] obs_f;
        int          rel;
        exp_t        e;
        rel   = cyc - t0;
        obs_f = obs_fields();
        fired = {(bus.err_out === 1'b1) && (err_prev !== 1'b1),
                 bus.done_out === 1'b1,
                 (bus.ub_rd_input_start_out | bus.ub_rd_bias_start_out | bus.ub_wr_addr_valid_out) === 1'b1,
                 bus.sys_switch_out === 1'b1,
                 bus.ub_rd_weight_start_out === 1'b1};
        if (fired[EV_STREAM]) begin
            n_total++;
            if ({bus.ub_rd_input_start_out, bus.ub_rd_bias_start_out, bus.ub_wr_addr_valid_out} !== 3'b111)
                $display("FAIL stream_strobes rel=%0d got=%b want=111", rel,
                         {bus.ub_rd_input_start_out, bus.ub_rd_bias_start_out, bus.ub_wr_addr_valid_out});
            else n_pass++;
        end
        for (int k = 0; k < 5; k++) begin
            if (fired[k]) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event got ev=%0d at rel=%0d want none", k, rel);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ev != ev_e'(k) || e.cyc != rel || e.f !== obs_f)
                        $display("FAIL event got ev=%0d rel=%0d f=%h want ev=%0d rel=%0d f=%h",
                                 k, rel, obs_f, e.ev, e.cyc, e.f);
                    else n_pass++;
                end
            end
        end
        err_prev = bus.err_out;
    end

    task automatic check_drained(input string name);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_missing_events got %0d outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic check_busy(input string name, input int r, input logic want);
        n_total++;
        if (bus.busy_out !== want || bus.cmd_ready_out !== !want)
            $display("FAIL %s_busy r=%0d got busy=%b ready=%b want busy=%b ready=%b",
                     name, r, bus.busy_out, bus.cmd_ready_out, want, !want);
        else n_pass++;
    endtask

    // Generic single-command runner: rows, wb pulse mask by cycle, busy window.
    task automatic run_cmd(input string name, input logic [47:0] f, input logic [5:0] rows,
                           input logic [31:0] wb_mask, input int busy_last, input int n_cyc);
        @(negedge clk);
        t0 = cyc;
        for (int r = 0; r <= n_cyc; r++) begin
            if (r > 0) @(negedge clk);
            bus.cmd_valid_in    = (r == 0);
            bus.vpu_wb_valid_in = wb_mask[r];
            if (r == 0) drive(f, rows);
            else drive(~f, ~rows);
            if (r > 0) check_busy(name, r, (r <= busy_last));
        end
        bus.vpu_wb_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.cmd_ready_out !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.cmd_ready_out);
        else n_pass++;
        n_total++;
        if ({bus.busy_out, bus.done_out, bus.err_out, bus.ub_rd_weight_start_out, bus.ub_rd_input_start_out,
             bus.ub_rd_bias_start_out, bus.sys_switch_out, bus.ub_wr_addr_valid_out, obs_fields()} !== '0)
            $display("FAIL reset_outputs got=%h want=0", {bus.busy_out, bus.done_out, bus.err_out, obs_fields()});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [47:0] f = 48'hA5C3_1E7B_92D4;
        push_front(0, f);
        push_ev(EV_DONE, 13, f);
        run_cmd("basic", f, 6'd2, (32'd1 << 10) | (32'd1 << 12), 13, 16);
        check_drained("basic");
    endtask

    task automatic test_rows_zero();
        logic [47:0] f = 48'h0F0F_3C3C_5AA5;
        push_front(0, f);
        push_ev(EV_DONE, 7, f);
        run_cmd("rows_zero", f, 6'd0, 32'd0, 7, 9);
        check_drained("rows_zero");
    endtask

    task automatic test_stray_wb();
        logic [47:0] f = 48'h1357_9BDF_2468;
        push_front(0, f);
        push_ev(EV_DONE, 10, f);
        run_cmd("stray_wb", f, 6'd1, (32'd1 << 0) | (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 9), 10, 12);
        check_drained("stray_wb");
    endtask

    task automatic test_stream_pulse();
        logic [47:0] f = 48'hFEDC_BA98_7654;
        push_front(0, f);
        push_ev(EV_DONE, 8, f);
        run_cmd("stream_pulse", f, 6'd1, (32'd1 << 6), 8, 10);
        check_drained("stream_pulse");
    endtask

    task automatic test_timeout();
        logic [47:0] f = 48'h2222_4444_8888;
        logic [47:0] g = 48'h9999_AAAA_1111;
        push_front(0, f);
        push_ev(EV_ERR, 7 + TIMEOUT, '0);
        run_cmd("timeout", f, 6'd3, (32'd1 << 8) | (32'd1 << 9), 6 + TIMEOUT, 9 + TIMEOUT);
        n_total++;
        if (bus.err_out !== 1'b1) $display("FAIL timeout_err_sticky got=%b want=1", bus.err_out);
        else n_pass++;
        check_drained("timeout");
        push_front(0, g);
        push_ev(EV_DONE, 7, g);
        @(negedge clk);
        t0 = cyc;
        bus.cmd_valid_in = 1'b1;
        drive(g, 6'd0);
        @(negedge clk);
        bus.cmd_valid_in = 1'b0;
        n_total++;
        if (bus.err_out !== 1'b0) $display("FAIL err_clear_on_accept got=%b want=0", bus.err_out);
        else n_pass++;
        repeat (8) @(negedge clk);
        check_drained("err_clear");
    endtask

    task automatic test_timeout_coincide();
        logic [47:0] f = 48'h0000_FFFF_0F0F;
        push_front(0, f);
        push_ev(EV_DONE, 7 + TIMEOUT, f);
        run_cmd("coincide", f, 6'd3, (32'd1 << 8) | (32'd1 << 9) | (32'd1 << (6 + TIMEOUT)), 7 + TIMEOUT, 9 + TIMEOUT);
        n_total++;
        if (bus.err_out !== 1'b0) $display("FAIL coincide_err got=%b want=0", bus.err_out);
        else n_pass++;
        check_drained("coincide");
    endtask

    task automatic test_back_to_back();
        logic [47:0] f1 = 48'h1111_2222_3333;
        logic [47:0] f2 = 48'hCCCC_DDDD_EEEE;
        push_front(0, f1);
        push_ev(EV_DONE, 7, f1);
        push_front(8, f2);
        push_ev(EV_DONE, 17, f2);
        @(negedge clk);
        t0 = cyc;
        for (int r = 0; r <= 19; r++) begin
            if (r > 0) @(negedge clk);
            bus.cmd_valid_in    = (r <= 8);
            bus.vpu_wb_valid_in = (r == 16);
            if (r == 0) drive(f1, 6'd0);
            else drive(f2, 6'd1);
            if (r > 0) check_busy("b2b", r, (r <= 7) || (r >= 9 && r <= 17));
        end
        bus.vpu_wb_valid_in = 1'b0;
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        logic [47:0] f = 48'h7777_5555_3333;
        push_front(0, f);
        @(negedge clk);
        t0 = cyc;
        for (int r = 0; r <= 22; r++) begin
            if (r > 0) @(negedge clk);
            bus.cmd_valid_in    = (r == 0);
            bus.vpu_wb_valid_in = (r == 8);
            rst                 = (r == 8);
            drive(f, 6'd2);
            if (r == 9) begin
                n_total++;
                if ({bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.err_out, bus.ub_rd_weight_start_out,
                     bus.ub_rd_input_start_out, bus.ub_rd_bias_start_out, bus.sys_switch_out,
                     bus.ub_wr_addr_valid_out, obs_fields()} !== {1'b1, 56'd0})
                    $display("FAIL reset_mid_outputs got ready=%b busy=%b done=%b f=%h want ready=1 rest 0",
                             bus.cmd_ready_out, bus.busy_out, bus.done_out, obs_fields());
                else n_pass++;
            end
            if (r > 0) check_busy("reset_mid", r, (r <= 8));
        end
        check_drained("reset_mid");
    endtask

    initial begin
        cyc = 0; t0 = 0; n_pass = 0; n_total = 0; err_prev = 1'b0;
        rst = 1'b1;
        bus.cmd_valid_in    = 1'b0;
        bus.vpu_wb_valid_in = 1'b0;
        drive('0, 6'd0);
        test_reset();
        test_basic();
        test_rows_zero();
        test_stray_wb();
        test_stream_pulse();
        test_timeout();
        test_timeout_coincide();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tpu_ctrl.md
TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 Parameter W_SETTLE, default 4: cycles spent in LOAD_W (2..15).
REQ-002 Parameter TIMEOUT, default 255: max cycles in WAIT_WB before error (1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid_in  in  1  command offered by host.
REQ-006 cmd_ready_out  out  1  controller can accept a command.
REQ-007 cmd_w_addr_in, cmd_w_loc_in, cmd_x_addr_in, cmd_x_loc_in, cmd_b_addr_in, cmd_b_loc_in, cmd_out_addr_in  in  6 each  weight, input, bias and writeback UB addresses/locations.
REQ-008 cmd_w_transpose_in, cmd_x_transpose_in  in  1 each  transpose flags.
REQ-009 cmd_pathway_in  in  4  VPU pathway select.
REQ-010 cmd_rows_in  in  6  number of VPU writeback valid pulses expected.
REQ-011 vpu_wb_valid_in  in  1  VPU output valid (lane 1), one pulse per written row.
REQ-012 ub_rd_weight_start_out, ub_rd_input_start_out, ub_rd_bias_start_out, sys_switch_out, ub_wr_addr_valid_out  out  1 each  single-cycle strobes to UB/systolic array.
REQ-013 ub_rd_weight_addr_out, ub_rd_weight_loc_out, ub_rd_input_addr_out, ub_rd_input_loc_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out, ub_wr_addr_out  out  6 each  registered command fields.
REQ-014 ub_rd_weight_transpose_out, ub_rd_input_transpose_out  out  1 each; vpu_data_pathway_out  out  4.
REQ-015 busy_out  out  1; done_out  out  1 (pulse); err_out  out  1 (sticky).

Function
REQ-016 States: IDLE, LOAD_W, SWITCH, STREAM, WAIT_WB, DONE; all outputs registered.
REQ-017 cmd_ready_out SHALL be 1 only in IDLE; accept = cmd_valid_in & cmd_ready_out; all cmd fields latched on accept.
REQ-018 Accept in cycle N -> state LOAD_W in N+1 with ub_rd_weight_start_out=1 in N+1 only.
REQ-019 LOAD_W SHALL last exactly W_SETTLE cycles, then SWITCH for 1 cycle with sys_switch_out=1.
REQ-020 STREAM SHALL last 1 cycle with ub_rd_input_start_out, ub_rd_bias_start_out, ub_wr_addr_valid_out all 1 together.
REQ-021 Address/loc/transpose/pathway outputs SHALL hold latched values from LOAD_W through DONE; 0 in IDLE.
REQ-022 8-bit wb counter cleared on accept; increments on vpu_wb_valid_in in STREAM or WAIT_WB; pulses in other states ignored.
REQ-023 In STREAM, if cmd_rows_in==0 -> next DONE; else next WAIT_WB.
REQ-024 WAIT_WB -> DONE in the cycle after counter reaches cmd_rows (pulse making count==rows included); extra pulses ignored.
REQ-025 8-bit timeout counter cleared on WAIT_WB entry, increments each WAIT_WB cycle; reaching TIMEOUT -> IDLE, err_out=1; if final wb pulse and timeout coincide, DONE wins.
REQ-026 DONE: done_out=1 for 1 cycle, then IDLE.
REQ-027 err_out SHALL clear on the next accepted command; busy_out=1 in every state except IDLE.
REQ-028 cmd_valid_in while busy SHALL be ignored (no latch, no state change).

Reset
REQ-029 rst=1 at any edge, including mid-operation, SHALL force IDLE, clear both counters, set every output to 0 except cmd_ready_out=1.
REQ-030 rst SHALL take precedence over accept, wb pulses and timeout in the same cycle.

Verification
REQ-031 Accept at cycle 0, W_SETTLE=4, rows=2, wb pulses at 10 and 12 -> weight_start@1, switch@5, input/bias/wr_addr_valid@6, done@13, busy 1..13.
REQ-032 rows=0 -> done_out the cycle after STREAM, no WAIT_WB, counter unused.
REQ-033 rows=3, only 2 wb pulses, TIMEOUT=10 -> IDLE after 10 WAIT_WB cycles, err_out=1, done_out never; next accept clears err_out.
REQ-034 cmd_valid_in held high through operation with changing fields -> only first fields used; second command accepted in IDLE cycle after DONE.
REQ-035 rst asserted during WAIT_WB -> next cycle IDLE, all strobes 0, cmd_ready_out=1, no done_out.
REQ-036 wb pulse in IDLE/LOAD_W then rows=1 command -> counter unaffected; DONE only after pulse in STREAM/WAIT_WB.
